// File: rtl/store_rmw_unit.sv
// store_rmw_unit
// Memory-write sequencer for the multicycle datapath. Performs SW directly
// and SH/SB as a read-modify-write of the containing word. Alignment or size
// errors abort the request with a misalign pulse and no memory write.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   start      request pulse, sampled only in IDLE
//   size       0=word, 1=halfword, 2=byte, 3=invalid
//   addr       byte address of the store
//   wdata      store data (bits [7:0] for SB, [15:0] for SH)
//   mem_rdata  memory read data, valid RD_LATENCY cycles after mem_addr
//   mem_addr   word-aligned address of the access
//   mem_wr     one-cycle memory write enable
//   mem_wdata  word written to memory
//   busy       high in every state except IDLE
//   done       one-cycle pulse on store completion
//   misalign   one-cycle pulse on alignment/size error
module store_rmw_unit #(
  parameter int RD_LATENCY = 1,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [31:0]       mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              misalign
);

  localparam int CNT_W = (RD_LATENCY < 2) ? 1 : $clog2(RD_LATENCY + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [31:0]       wdata_q;
  logic [31:0]       merge_q;
  logic [CNT_W-1:0]  cnt_q;

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
    return (sz == 2'd3) || ((sz == 2'd0) && (lo != 2'b00)) || ((sz == 2'd1) && lo[0]);
  endfunction

  // Replace only the addressed lane(s) of the previously read word; a full
  // word store ignores the old contents entirely.
  function automatic logic [31:0] merge_lanes(input logic [1:0]  sz,
                                              input logic [1:0]  lo,
                                              input logic [31:0] old,
                                              input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    case (sz)
      2'd0: r = wd;
      2'd1: begin
        if (lo[1]) r[31:16] = wd[15:0];
        else       r[15:0]  = wd[15:0];
      end
      default: begin
        case (lo)
          2'd0:    r[7:0]   = wd[7:0];
          2'd1:    r[15:8]  = wd[7:0];
          2'd2:    r[23:16] = wd[7:0];
          default: r[31:24] = wd[7:0];
        endcase
      end
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_wr    = 1'b0;
    done      = 1'b0;
    misalign  = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start) begin
          if (is_misaligned(size, addr[1:0])) state_nxt = S_ERR;
          else if (size == 2'd0)              state_nxt = S_WRITE;
          else                                state_nxt = S_READ;
        end
      end
      S_READ:  state_nxt = S_WAIT;
      S_WAIT:  if (cnt_q == CNT_W'(1)) state_nxt = S_WRITE;
      S_WRITE: begin
        mem_wr    = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      S_ERR: begin
        misalign  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request capture, read-latency counter and merge register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      size_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      cnt_q   <= '0;
    end else begin
      if ((state == S_IDLE) && start) begin
        addr_q  <= addr;
        size_q  <= size;
        wdata_q <= wdata;
      end
      if (state == S_READ)      cnt_q <= CNT_W'(RD_LATENCY);
      else if (state == S_WAIT) cnt_q <= cnt_q - CNT_W'(1);
      // The last WAIT cycle is the one where read data for mem_addr is valid.
      if ((state == S_WAIT) && (cnt_q == CNT_W'(1))) merge_q <= mem_rdata;
    end
  end

  // Outputs derive only from registered request state
  assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata = merge_lanes(size_q, addr_q[1:0], merge_q, wdata_q);

endmodule

// File: tb/tb_store_rmw_unit.sv
// Testbench for store_rmw_unit. Two instances (read latency 1 and 3), each
// with its own behavioural memory. A reference model predicts, per request,
// the cycle of the write, the done/misalign pulse, the busy window and the
// merged word; a compare branch checks every cycle against it.
module tb_store_rmw_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  logic        rst_s    [2];
  logic        start_s  [2];
  logic [1:0]  size_s   [2];
  logic [31:0] addr_s   [2];
  logic [31:0] wdata_s  [2];
  logic [31:0] rdata_s  [2];
  logic [31:0] maddr_s  [2];
  logic        mem_wr_s [2];
  logic [31:0] mwdata_s [2];
  logic        busy_s   [2];
  logic        done_s   [2];
  logic        mis_s    [2];

  store_rmw_unit #(.RD_LATENCY(1), .ADDR_W(32)) dut0 (
    .clk(clk), .reset(rst_s[0]), .start(start_s[0]), .size(size_s[0]),
    .addr(addr_s[0]), .wdata(wdata_s[0]), .mem_rdata(rdata_s[0]),
    .mem_addr(maddr_s[0]), .mem_wr(mem_wr_s[0]), .mem_wdata(mwdata_s[0]),
    .busy(busy_s[0]), .done(done_s[0]), .misalign(mis_s[0]));

  store_rmw_unit #(.RD_LATENCY(3), .ADDR_W(32)) dut1 (
    .clk(clk), .reset(rst_s[1]), .start(start_s[1]), .size(size_s[1]),
    .addr(addr_s[1]), .wdata(wdata_s[1]), .mem_rdata(rdata_s[1]),
    .mem_addr(maddr_s[1]), .mem_wr(mem_wr_s[1]), .mem_wdata(mwdata_s[1]),
    .busy(busy_s[1]), .done(done_s[1]), .misalign(mis_s[1]));

  // Memories: 64 words each, read data delayed by the instance's latency.
  logic [31:0] mem  [2][64];
  logic [31:0] pipe [2][3];
  logic        pl_en  [2];
  logic [5:0]  pl_idx [2];
  logic [31:0] pl_val [2];

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      pipe[g][0] <= mem[g][maddr_s[g][7:2]];
      pipe[g][1] <= pipe[g][0];
      pipe[g][2] <= pipe[g][1];
      if (mem_wr_s[g])  mem[g][maddr_s[g][7:2]] <= mwdata_s[g];
      else if (pl_en[g]) mem[g][pl_idx[g]] <= pl_val[g];
    end
  end
  assign rdata_s[0] = pipe[0][0];
  assign rdata_s[1] = pipe[1][2];

  // Reference model state
  logic [31:0] mdl [2][64];
  int unsigned x_start [2];
  int unsigned x_wr    [2];
  int unsigned x_end   [2];
  logic        x_err   [2];
  logic [31:0] x_data  [2];
  logic [31:0] x_addr  [2];

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic load(input int g, input int idx, input logic [31:0] val);
    @(negedge clk);
    pl_en[g] = 1'b1; pl_idx[g] = 6'(idx); pl_val[g] = val;
    mdl[g][idx] = val;
    @(posedge clk); #1;
    pl_en[g] = 1'b0;
  endtask

  task automatic pin(input int g, input int idx, input logic [31:0] val);
    chk($sformatf("g%0d mem[%0d]", g, idx), mem[g][idx], val);
    chk($sformatf("g%0d model[%0d]", g, idx), mdl[g][idx], val);
  endtask

  task automatic issue(input int g, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input bit hold);
    int unsigned k;
    int unsigned lat;
    int          sh;
    logic [31:0] old;
    logic [31:0] nw;
    lat = (g == 0) ? 1 : 3;
    @(negedge clk);
    size_s[g] = sz; addr_s[g] = a; wdata_s[g] = wd; start_s[g] = 1'b1;
    @(posedge clk); #1;
    k = ecnt;
    start_s[g] = hold;
    size_s[g] = 2'($urandom); addr_s[g] = $urandom; wdata_s[g] = $urandom;
    x_start[g] = k;
    x_addr[g]  = {a[31:2], 2'b00};
    if (sz == 2'd3 || (sz == 2'd0 && a[1:0] != 2'b00) || (sz == 2'd1 && a[0])) begin
      x_err[g] = 1'b1; x_wr[g] = 0; x_end[g] = k + 1;
    end else begin
      old = mdl[g][a[7:2]];
      case (sz)
        2'd0: nw = wd;
        2'd1: begin
          sh = a[1] ? 16 : 0;
          nw = (old & ~(32'h0000_FFFF << sh)) | ((wd & 32'h0000_FFFF) << sh);
        end
        default: begin
          sh = 8 * int'(a[1:0]);
          nw = (old & ~(32'h0000_00FF << sh)) | ((wd & 32'h0000_00FF) << sh);
        end
      endcase
      x_err[g]  = 1'b0;
      x_wr[g]   = (sz == 2'd0) ? k + 1 : k + 2 + lat;
      x_end[g]  = x_wr[g] + 1;
      x_data[g] = nw;
      mdl[g][a[7:2]] = nw;
    end
  endtask

  // Waits to the first idle cycle after the request; optionally toggles start
  // randomly meanwhile (including the done/misalign cycle, where it is ignored).
  task automatic finish_store(input int g, input bit noisy);
    forever begin
      @(negedge clk);
      if (ecnt + 1 > x_end[g]) break;
      if (noisy) start_s[g] = 1'($urandom_range(0, 1));
    end
    start_s[g] = 1'b0;
  endtask

  task automatic store(input int g, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input bit hold, input bit noisy);
    issue(g, sz, a, wd, hold);
    finish_store(g, noisy);
  endtask

  task automatic reset_in_wait(input int g);
    logic [31:0] saved;
    saved = mdl[g][16];
    issue(g, 2'd2, 32'h0000_0041, 32'h0000_0099, 1'b0);
    @(posedge clk); @(posedge clk); #2;
    rst_s[g] = 1'b1;
    mdl[g][16] = saved;
    x_start[g] = 0; x_wr[g] = 0; x_end[g] = 0; x_err[g] = 1'b0; x_addr[g] = '0;
    #1;
    chk($sformatf("g%0d busy on reset", g), 32'(busy_s[g]), 32'd0);
    chk($sformatf("g%0d mem_wr on reset", g), 32'(mem_wr_s[g]), 32'd0);
    repeat (3) @(posedge clk);
    #2 rst_s[g] = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  initial begin
    for (int g = 0; g < 2; g++) begin
      rst_s[g] = 1'b1; start_s[g] = 1'b0; size_s[g] = '0; addr_s[g] = '0;
      wdata_s[g] = '0; pl_en[g] = 1'b0; pl_idx[g] = '0; pl_val[g] = '0;
      x_start[g] = 0; x_wr[g] = 0; x_end[g] = 0; x_err[g] = 1'b0;
      x_data[g] = '0; x_addr[g] = '0;
    end
    fork
      begin : compare
        int unsigned cur;
        logic ewr, edone, emis, ebusy;
        forever begin
          @(negedge clk);
          cur = ecnt + 1;
          for (int g = 0; g < 2; g++) begin
            ewr   = (x_wr[g] != 0) && (cur == x_wr[g]);
            edone = !x_err[g] && (x_end[g] != 0) && (cur == x_end[g]);
            emis  = x_err[g] && (x_end[g] != 0) && (cur == x_end[g]);
            ebusy = (x_start[g] != 0) && (cur > x_start[g]) && (cur <= x_end[g]);
            chk($sformatf("g%0d mem_wr", g),   32'(mem_wr_s[g]), 32'(ewr));
            chk($sformatf("g%0d done", g),     32'(done_s[g]),   32'(edone));
            chk($sformatf("g%0d misalign", g), 32'(mis_s[g]),    32'(emis));
            chk($sformatf("g%0d busy", g),     32'(busy_s[g]),   32'(ebusy));
            chk($sformatf("g%0d mem_addr", g), maddr_s[g],       x_addr[g]);
            if (ewr) chk($sformatf("g%0d mem_wdata", g), mwdata_s[g], x_data[g]);
          end
        end
      end
      begin : stimulus
        repeat (2) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
          chk($sformatf("g%0d reset mem_addr", g),  maddr_s[g],        32'd0);
          chk($sformatf("g%0d reset mem_wdata", g), mwdata_s[g],       32'd0);
          chk($sformatf("g%0d reset busy", g),      32'(busy_s[g]),    32'd0);
          chk($sformatf("g%0d reset done", g),      32'(done_s[g]),    32'd0);
        end
        #1 rst_s[0] = 1'b0; rst_s[1] = 1'b0;
        for (int i = 0; i < 64; i++) begin
          load(0, i, $urandom);
          load(1, i, $urandom);
        end

        // Word store
        load(0, 16, 32'h0);
        store(0, 2'd0, 32'h40, 32'hDEAD_BEEF, 1'b0, 1'b0);
        pin(0, 16, 32'hDEAD_BEEF);
        // Byte stores, all lanes
        load(0, 16, 32'hAABB_CCDD); store(0, 2'd2, 32'h41, 32'h1234_5678, 1'b0, 1'b0); pin(0, 16, 32'hAABB_78DD);
        load(0, 16, 32'hAABB_CCDD); store(0, 2'd2, 32'h40, 32'h1234_5678, 1'b0, 1'b0); pin(0, 16, 32'hAABB_CC78);
        load(0, 16, 32'hAABB_CCDD); store(0, 2'd2, 32'h42, 32'h1234_5678, 1'b0, 1'b0); pin(0, 16, 32'hAA78_CCDD);
        load(0, 16, 32'hAABB_CCDD); store(0, 2'd2, 32'h43, 32'h1234_5678, 1'b0, 1'b0); pin(0, 16, 32'h78BB_CCDD);
        // Halfword stores
        load(0, 16, 32'hAABB_CCDD); store(0, 2'd1, 32'h42, 32'h0000_BEEF, 1'b0, 1'b0); pin(0, 16, 32'hBEEF_CCDD);
        load(0, 16, 32'hAABB_CCDD); store(0, 2'd1, 32'h40, 32'h0000_BEEF, 1'b0, 1'b0); pin(0, 16, 32'hAABB_BEEF);
        // Errors leave memory untouched
        store(0, 2'd0, 32'h42, 32'h1111_1111, 1'b0, 1'b0);
        store(0, 2'd1, 32'h41, 32'h2222_2222, 1'b0, 1'b0);
        store(0, 2'd3, 32'h40, 32'h3333_3333, 1'b0, 1'b0);
        pin(0, 16, 32'hAABB_BEEF);
        // start held high through the whole sequence and the done cycle
        load(0, 16, 32'hAABB_CCDD); store(0, 2'd2, 32'h42, 32'h0000_00A5, 1'b1, 1'b0); pin(0, 16, 32'hAAA5_CCDD);
        // Reset during WAIT, then a normal byte store
        load(1, 16, 32'h1122_3344);
        reset_in_wait(1);
        pin(1, 16, 32'h1122_3344);
        store(1, 2'd2, 32'h41, 32'h0000_0099, 1'b0, 1'b0); pin(1, 16, 32'h1122_9944);
        // Read latency 3
        load(1, 16, 32'hAABB_CCDD); store(1, 2'd2, 32'h43, 32'h1234_5678, 1'b0, 1'b0); pin(1, 16, 32'h78BB_CCDD);

        // Randomized requests with noisy start
        for (int n = 0; n < 80; n++) begin
          store(n % 2, 2'($urandom_range(0, 3)), $urandom, $urandom, 1'b0, 1'b1);
        end
        for (int g = 0; g < 2; g++)
          for (int i = 0; i < 64; i++)
            chk($sformatf("g%0d final mem[%0d]", g, i), mem[g][i], mdl[g][i]);
      end
    join_any
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/store_rmw_unit.md
Name: store_rmw_unit

Overview:
Memory-write sequencer for the multicycle datapath. It is the write-direction counterpart of the load/write-back path: it takes a register value and performs SW, SH or SB into the word-addressed data memory. Sub-word stores use a read-modify-write sequence. The control unit pulses start and waits for done or misalign; misalign feeds the exception logic.

Parameters:
RD_LATENCY, 1, memory read latency in cycles (address presented -> mem_rdata valid); legal range >= 1
ADDR_W, 32, byte address width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
size  input  2  0=word, 1=halfword, 2=byte, 3=invalid
addr  input  ADDR_W  byte address of the store
wdata  input  32  store data (register B); bits [7:0] for SB, [15:0] for SH
mem_rdata  input  32  memory read data
mem_addr  output  ADDR_W  word-aligned address {addr_q[ADDR_W-1:2],2'b00}
mem_wr  output  1  memory write enable, one cycle
mem_wdata  output  32  word written to memory
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on store completion
misalign  output  1  one-cycle pulse on alignment or size error; no memory write occurs

Behaviour:
- Reset (asynchronous): state goes to IDLE immediately; mem_wr, done, misalign, busy are 0; mem_addr, mem_wdata and the latched registers are 0. Reset mid-sequence aborts the sequence with no write; mem_wr deasserts combinationally with reset.
- Inputs are captured into addr_q, size_q, wdata_q on the start edge. Later input changes have no effect. start is ignored while busy.
- Byte lanes are little-endian: lane n = bits [8n+7:8n], with n = addr_q[1:0]. Halfword lane = addr_q[1].
- State machine: IDLE, READ, WAIT, WRITE, DONE, ERR.
  - IDLE + start:
    - Error (size=3; size=0 with addr[1:0]!=0; size=1 with addr[0]!=0) -> ERR.
    - size=0 aligned -> WRITE.
    - Otherwise -> READ.
  - READ: mem_addr driven, mem_wr=0; load wait counter with RD_LATENCY; -> WAIT.
  - WAIT: counter decrements each cycle. On its final cycle (count=1), mem_rdata is captured into a merge register; -> WRITE.
  - WRITE: mem_wr=1 for exactly one cycle.
    - Word: mem_wdata = wdata_q.
    - Half: captured word with the selected 16-bit lane replaced by wdata_q[15:0].
    - Byte: captured word with the selected 8-bit lane replaced by wdata_q[7:0].
    - Unselected lanes are written back unchanged. -> DONE.
  - DONE: done=1; -> IDLE.
  - ERR: misalign=1, mem_wr stays 0; -> IDLE.
- Latency (start sampled at edge k):
  - Word store: mem_wr high in cycle k+1, done in cycle k+2.
  - Sub-word store: mem_wr high in cycle k+2+RD_LATENCY, done in cycle k+3+RD_LATENCY.
  - Error: misalign in cycle k+1.
- A new start presented in the same cycle as done or misalign is ignored. It is accepted on the next cycle, when the block is back in IDLE.
- mem_addr stays stable from READ through WRITE. It holds its last value in IDLE.
- Outputs are driven from registered state only. There is no combinational path from start to mem_wr.

Test Plan:
- Word store: memory[0x40]=0, start size=0 addr=0x40 wdata=0xDEADBEEF -> one mem_wr pulse at cycle k+1, mem_addr=0x40, memory[0x40]=0xDEADBEEF; done at k+2; misalign never asserts.
- Byte store, all four lanes (RD_LATENCY=1): memory[0x40]=0xAABBCCDD, SB addr=0x41 wdata=0x12345678 -> read at 0x40, mem_wdata=0xAABB78DD, done at k+4. Repeat for offsets 0, 2, 3 -> 0xAABBCC78, 0xAA78CCDD, 0x78BBCCDD.
- Halfword store: memory[0x40]=0xAABBCCDD, SH addr=0x42 wdata=0x0000BEEF -> memory=0xBEEFCCDD. SH addr=0x40 -> memory=0xAABBBEEF.
- Misalignment and invalid size: SW addr=0x42, SH addr=0x41, and size=3 -> misalign pulse at k+1, no mem_wr, memory unchanged, busy low at k+2.
- Robustness: start held high during a sub-word store -> exactly one store executes. Reset asserted during WAIT -> mem_wr never asserts, busy=0 immediately, memory unchanged. The next SB after reset completes correctly.
- Latency sweep: RD_LATENCY=3, SB addr=0x43 -> mem_wr at k+5, done at k+6, merged data correct.
